// File: rtl/nonce_decoder_pkg.sv
// Shared constants and helpers for the nonce decoder.
// Nonce width and prefix/index width derivation.
package nonce_decoder_pkg;

  localparam int NONCE_W = 32;

  function automatic int idx_w(input int cores);
    return $clog2(cores);
  endfunction

  function automatic int prefix_w(input int cores);
    return NONCE_W - $clog2(cores);
  endfunction

endpackage

// File: rtl/processorResultsIfc.sv
// Per-cycle result bundle from the hashing cores.
// Shared nonce prefix plus one success flag per core.
interface processorResultsIfc
  import nonce_decoder_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input logic clk
);

  logic [prefix_w(NUM_CORES)-1:0] nonce_prefix;
  logic [NUM_CORES-1:0]           success;

  modport reader (
    input clk,
    input nonce_prefix,
    input success
  );

endinterface

// File: rtl/nonce_decoder_lowest_set_index.sv
// Priority encoder: position of the lowest set bit.
// Lower core index wins when several cores succeed.
module lowest_set_index #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic                 any,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  // scan high to low so the lowest set bit is written last
  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any   = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/nonce_decoder.sv
// Turns per-core success flags into a winning nonce.
// Ignores pipeline-fill cycles; first found nonce is held.
module nonce_decoder
  import nonce_decoder_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int BROADCAST_CNT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               newblock_i,
  processorResultsIfc.reader rawinput_i,
  output logic               valid_o,
  output logic               success_o,
  output logic [NONCE_W-1:0] nonce_o
);

  localparam int IW = idx_w(NUM_CORES);
  localparam int CW = $clog2(BROADCAST_CNT + 1);
  localparam logic [CW-1:0] FULL = CW'(BROADCAST_CNT);

  logic [CW-1:0] fill;
  logic          armed;
  logic          any;
  logic [IW-1:0] index;
  logic          accept;

  lowest_set_index #(
    .N (NUM_CORES)
  ) u_lsi (
    .vec   (rawinput_i.success),
    .any   (any),
    .index (index)
  );

  // a cycle counts only once a block has started and the pipe is full
  always_comb begin
    accept = valid_i && !newblock_i && armed && (fill == FULL);
  end

  // fill counter, sticky first-found result and registered valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill      <= '0;
      armed     <= 1'b0;
      valid_o   <= 1'b0;
      success_o <= 1'b0;
      nonce_o   <= '0;
    end else if (newblock_i) begin
      fill      <= valid_i ? CW'(1) : '0;
      armed     <= 1'b1;
      valid_o   <= 1'b0;
      success_o <= 1'b0;
      nonce_o   <= '0;
    end else begin
      valid_o <= accept;
      if (valid_i && fill != FULL) begin
        fill <= fill + CW'(1);
      end
      if (accept && any && !success_o) begin
        success_o <= 1'b1;
        nonce_o   <= {rawinput_i.nonce_prefix, index};
      end
    end
  end

endmodule

// File: tb/tb_nonce_decoder.sv
// Randomized and directed check of nonce_decoder
// against a behavioural model of the block rules.
module tb_nonce_decoder;

  localparam int NC = 4;
  localparam int BC = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        newblock_i;
  logic        valid_o;
  logic        success_o;
  logic [31:0] nonce_o;

  int ncmp = 0;
  int nerr = 0;

  // behavioural model state
  bit armed_m;
  int fill_m;
  bit held_m;
  int nonce_m;
  bit vexp_m;

  always #5 clk = ~clk;

  processorResultsIfc #(.NUM_CORES(NC)) ifc (.clk(clk));

  nonce_decoder #(
    .NUM_CORES     (NC),
    .BROADCAST_CNT (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .newblock_i (newblock_i),
    .rawinput_i (ifc),
    .valid_o    (valid_o),
    .success_o  (success_o),
    .nonce_o    (nonce_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    armed_m = 0;
    fill_m  = 0;
    held_m  = 0;
    nonce_m = 0;
    vexp_m  = 0;
  endtask

  function automatic int lowest(input int s);
    for (int k = 0; k < NC; k++)
      if (s[k]) return k;
    return -1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, vexp_m});
    chk({tag, ".success"}, {31'd0, success_o}, {31'd0, held_m});
    chk({tag, ".nonce"}, nonce_o, nonce_m);
  endtask

  // drive one cycle, advance the model, compare after the edge
  task automatic step(input string tag, input bit v, input bit nb,
                      input int pre, input int s);
    bit acc;
    valid_i          = v;
    newblock_i       = nb;
    ifc.nonce_prefix = 30'(pre);
    ifc.success      = 4'(s);
    @(posedge clk);
    #1;
    if (nb) begin
      armed_m = 1;
      fill_m  = v ? 1 : 0;
      held_m  = 0;
      nonce_m = 0;
      vexp_m  = 0;
    end else if (v) begin
      acc    = armed_m && fill_m == BC;
      vexp_m = acc;
      if (fill_m < BC) fill_m++;
      if (acc && (s % 16) != 0 && !held_m) begin
        held_m  = 1;
        nonce_m = (pre % (1 << 30)) * NC + lowest(s);
      end
    end else begin
      vexp_m = 0;
    end
    check_all(tag);
  endtask

  task automatic fill_block(input string tag, input int pre);
    step(tag, 1, 1, pre, 0);
    for (int i = 0; i < BC - 1; i++) step(tag, 1, 0, pre, 0);
  endtask

  initial begin
    rst              = 1'b0;
    valid_i          = 0;
    newblock_i       = 0;
    ifc.nonce_prefix = '0;
    ifc.success      = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // no acceptance before a newblock, even with many valid cycles
    for (int i = 0; i < 8; i++) step("pre_block", 1, 0, 7, 1);

    // pipe fill, then first valid on the 6th edge
    fill_block("fill", 5);
    chk("fill_no_valid", {31'd0, valid_o}, 32'd0);
    step("first_valid", 1, 0, 5, 0);
    chk("first_valid_const", {31'd0, valid_o}, 32'd1);
    chk("first_nonce_zero", nonce_o, 32'd0);

    // single success on core 2
    step("succ", 1, 0, 5, 4'b0100);
    chk("succ_const", {31'd0, success_o}, 32'd1);
    chk("nonce22", nonce_o, 32'd22);

    // first-found wins, lowest index of 1010 is 1
    fill_block("fill2", 9);
    step("two_hits", 1, 0, 9, 4'b1010);
    step("later_hit", 1, 0, 3, 4'b0001);
    chk("first_wins", nonce_o, 32'd37);

    // successes during fill are ignored
    step("fill3", 1, 1, 11, 1);
    for (int i = 0; i < BC - 1; i++) step("fill3", 1, 0, 11, 1);
    chk("fill_ignored", {31'd0, success_o}, 32'd0);
    step("after_fill3", 1, 0, 11, 4'b1000);
    chk("nonce47", nonce_o, 32'd47);

    // newblock clears a held success
    step("clear", 1, 1, 2, 4'b0001);
    chk("clear_succ", {31'd0, success_o}, 32'd0);
    chk("clear_nonce", nonce_o, 32'd0);
    for (int i = 0; i < BC - 1; i++) step("suppress", 1, 0, 2, 0);

    // long valid run then drop; counter kept across the gap
    for (int i = 0; i < 30; i++) step("run", 1, 0, 2, 0);
    step("drop", 0, 0, 2, 0);
    chk("drop_const", {31'd0, valid_o}, 32'd0);
    step("resume", 1, 0, 2, 4'b0010);
    chk("resume_valid", {31'd0, valid_o}, 32'd1);
    chk("resume_nonce", nonce_o, 32'd9);

    // asynchronous reset between edges
    step("pre_rst", 1, 0, 2, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    rst = 1'b1;
    for (int i = 0; i < 7; i++) step("post_rst", 1, 0, 4, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int s;
      s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : 0;
      step("rand", $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0,
           int'($urandom), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
